matrix_job_sequencer: RTL and testbench

- Parametrised successor to the coprocessor's fixed 5x5 load/compute/store FSM.
- Accepts a command (op, matrix size), loads only the active n x n operand elements from the shared operand memory and drives the ALU through a start/done handshake.
- Writes the n x n result back to the result region.
- Runs on the system clock; no internal clock divider; command interface replaces the button.

---
 rtl/matrix_job_sequencer_if.sv | 38 +++
 rtl/matrix_job_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_matrix_job_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_job_sequencer_if.sv
// Command, operand-memory and ALU bus of the matrix job sequencer.
// The master modport is the sequencer side; the slave modport is the memory/ALU/host side.
interface matrix_job_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 5,
  parameter int ADDR_W = 7
);
  localparam int VEC_W = MAX_N * MAX_N * DATA_W;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_op;
  logic [1:0]          cmd_size;

  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [2*DATA_W-1:0] mem_wdata;
  logic [2*DATA_W-1:0] mem_rdata;

  logic [VEC_W-1:0]    alu_a;
  logic [VEC_W-1:0]    alu_b;
  logic [2:0]          alu_op;
  logic [1:0]          alu_size;
  logic                alu_start;
  logic                alu_done;
  logic [VEC_W-1:0]    alu_result;
  logic                alu_overflow;

  modport master (
    input  cmd_valid, cmd_op, cmd_size, mem_rdata, alu_done, alu_result, alu_overflow,
    output cmd_ready, mem_addr, mem_we, mem_wdata, alu_a, alu_b, alu_op, alu_size, alu_start
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_size, mem_rdata, alu_done, alu_result, alu_overflow,
    input  cmd_ready, mem_addr, mem_we, mem_wdata, alu_a, alu_b, alu_op, alu_size, alu_start
  );
endinterface

// File: rtl/matrix_job_sequencer.sv
// Load/compute/store sequencer for n x n matrix jobs (n = 2..MAX_N) on a lane-parallel ALU.
// Optional feature macro MATRIX_SEQ_OVF_WORD_EN: writes the overflow flag as an extra result word.
module matrix_job_sequencer #(
  parameter int DATA_W      = 8,
  parameter int MAX_N       = 5,
  parameter int ADDR_W      = 7,
  parameter int SRC_BASE    = 0,
  parameter int RES_BASE    = 25,
  parameter int MEM_LAT     = 1,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  matrix_job_sequencer_if.master  bus,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    overflow_flag
);

  localparam int LANES  = MAX_N * MAX_N;
  localparam int VEC_W  = LANES * DATA_W;
  localparam int IDX_W  = $clog2(MAX_N);
  localparam int LANE_W = $clog2(LANES);
  localparam int LAT_W  = 2;
  localparam int TMO_W  = $clog2(ALU_TIMEOUT + 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOAD_ISSUE = 3'd1;
  localparam logic [2:0] LOAD_WAIT  = 3'd2;
  localparam logic [2:0] START      = 3'd3;
  localparam logic [2:0] COMPUTE    = 3'd4;
  localparam logic [2:0] STORE      = 3'd5;
`ifdef MATRIX_SEQ_OVF_WORD_EN
  localparam logic [2:0] FLAG       = 3'd6;
`endif
  localparam logic [2:0] FINISH     = 3'd7;

  logic [2:0]          state_r;
  logic [IDX_W-1:0]    row_r;
  logic [IDX_W-1:0]    col_r;
  logic [2:0]          op_r;
  logic [1:0]          size_r;
  logic [LAT_W-1:0]    lat_r;
  logic [TMO_W-1:0]    tmo_r;
  logic [VEC_W-1:0]    result_r;

  logic [ADDR_W-1:0]   mem_addr_r;
  logic                mem_we_r;
  logic [2*DATA_W-1:0] mem_wdata_r;
  logic [VEC_W-1:0]    alu_a_r;
  logic [VEC_W-1:0]    alu_b_r;
  logic                alu_start_r;
  logic                done_r;
  logic                error_r;
  logic                ovf_r;

  logic [IDX_W-1:0]    nm1_s;
  logic                col_wrap_s;
  logic                last_s;
  logic [IDX_W-1:0]    next_row_s;
  logic [IDX_W-1:0]    next_col_s;
  logic [LANE_W-1:0]   lane_s;
  logic [LANE_W-1:0]   next_lane_s;

  // Element walk: lane index of the current and following element, stride MAX_N.
  always_comb begin
    nm1_s      = IDX_W'(size_r) + IDX_W'(1'b1);
    col_wrap_s = (col_r == nm1_s);
    last_s     = col_wrap_s && (row_r == nm1_s);
    if (col_wrap_s) begin
      next_col_s = '0;
      next_row_s = row_r + IDX_W'(1'b1);
    end else begin
      next_col_s = col_r + IDX_W'(1'b1);
      next_row_s = row_r;
    end
    lane_s      = LANE_W'(row_r) * LANE_W'(MAX_N) + LANE_W'(col_r);
    next_lane_s = LANE_W'(next_row_s) * LANE_W'(MAX_N) + LANE_W'(next_col_s);
  end

  // Job FSM; bus outputs are registered on entry to the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      row_r       <= '0;
      col_r       <= '0;
      op_r        <= 3'd0;
      size_r      <= 2'd0;
      lat_r       <= '0;
      tmo_r       <= '0;
      result_r    <= '0;
      mem_addr_r  <= '0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= '0;
      alu_a_r     <= '0;
      alu_b_r     <= '0;
      alu_start_r <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      alu_start_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_r       <= bus.cmd_op;
            size_r     <= bus.cmd_size;
            error_r    <= 1'b0;
            ovf_r      <= 1'b0;
            alu_a_r    <= '0;
            alu_b_r    <= '0;
            row_r      <= '0;
            col_r      <= '0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= ADDR_W'(SRC_BASE);
            state_r    <= LOAD_ISSUE;
          end
        end
        LOAD_ISSUE: begin
          lat_r   <= '0;
          state_r <= LOAD_WAIT;
        end
        LOAD_WAIT: begin
          // Address is held through the wait; data is valid on the last wait cycle.
          if (lat_r == LAT_W'(MEM_LAT - 1)) begin
            alu_a_r[lane_s*DATA_W +: DATA_W] <= bus.mem_rdata[DATA_W-1:0];
            alu_b_r[lane_s*DATA_W +: DATA_W] <= bus.mem_rdata[2*DATA_W-1:DATA_W];
            row_r <= next_row_s;
            col_r <= next_col_s;
            if (last_s) begin
              alu_start_r <= 1'b1;
              tmo_r       <= '0;
              state_r     <= START;
            end else begin
              mem_addr_r <= ADDR_W'(SRC_BASE) + ADDR_W'(next_lane_s);
              state_r    <= LOAD_ISSUE;
            end
          end else begin
            lat_r <= lat_r + LAT_W'(1'b1);
          end
        end
        START: begin
          tmo_r   <= '0;
          state_r <= COMPUTE;
        end
        COMPUTE: begin
          // A done arriving on the timeout cycle still counts as success.
          if (bus.alu_done) begin
            result_r    <= bus.alu_result;
            ovf_r       <= bus.alu_overflow;
            row_r       <= '0;
            col_r       <= '0;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= ADDR_W'(RES_BASE);
            mem_wdata_r <= {{DATA_W{1'b0}}, bus.alu_result[DATA_W-1:0]};
            state_r     <= STORE;
          end else if (tmo_r == TMO_W'(ALU_TIMEOUT - 1)) begin
            error_r <= 1'b1;
            done_r  <= 1'b1;
            state_r <= FINISH;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1'b1);
          end
        end
        STORE: begin
          row_r <= next_row_s;
          col_r <= next_col_s;
          if (last_s) begin
`ifdef MATRIX_SEQ_OVF_WORD_EN
            mem_addr_r  <= ADDR_W'(RES_BASE) + ADDR_W'(LANES);
            mem_wdata_r <= {{(2*DATA_W-1){1'b0}}, ovf_r};
            state_r     <= FLAG;
`else
            mem_we_r <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= FINISH;
`endif
          end else begin
            mem_addr_r  <= ADDR_W'(RES_BASE) + ADDR_W'(next_lane_s);
            mem_wdata_r <= {{DATA_W{1'b0}}, result_r[next_lane_s*DATA_W +: DATA_W]};
          end
        end
`ifdef MATRIX_SEQ_OVF_WORD_EN
        FLAG: begin
          mem_we_r <= 1'b0;
          done_r   <= 1'b1;
          state_r  <= FINISH;
        end
`endif
        FINISH: begin
          mem_we_r <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          mem_we_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_r == IDLE);
  assign busy          = (state_r != IDLE);
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.alu_op    = op_r;
  assign bus.alu_size  = size_r;
  assign bus.alu_start = alu_start_r;
  assign done          = done_r;
  assign error         = error_r;
  assign overflow_flag = ovf_r;

endmodule

// File: tb/tb_matrix_job_sequencer.sv
// Scoreboard bench: dut1 (MEM_LAT=1, ALU_TIMEOUT=10) and dut3 (MEM_LAT=3) with memory and ALU models.
module tb_matrix_job_sequencer;
  localparam int DATA_W = 8;
  localparam int MAX_N  = 5;
  localparam int ADDR_W = 7;
  localparam int LANES  = MAX_N * MAX_N;
  localparam int VEC_W  = LANES * DATA_W;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int op; int size; int lane; int aval; } st_t;
  typedef struct { int err; int ovf; int lat; } dn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;
  logic busy1, done1, err1, ovf1;
  logic busy3, done3, err3, ovf3;
  logic hang1 = 1'b0;
  logic ovf_in1 = 1'b0;
  logic st1 = 1'b0;
  logic st3 = 1'b0;
  logic [15:0] rd1;
  logic [15:0] p0, p1, p2;
  logic [15:0] mem1 [0:127];
  logic [15:0] mem3 [0:127];

  int checks = 0;
  int errors = 0;
  wr_t wq1[$];
  wr_t wq3[$];
  st_t sq1[$];
  st_t sq3[$];
  dn_t dq1[$];
  dn_t dq3[$];

  matrix_job_sequencer_if #(.DATA_W(DATA_W), .MAX_N(MAX_N), .ADDR_W(ADDR_W)) b1 ();
  matrix_job_sequencer_if #(.DATA_W(DATA_W), .MAX_N(MAX_N), .ADDR_W(ADDR_W)) b3 ();

  matrix_job_sequencer #(.MEM_LAT(1), .ALU_TIMEOUT(10)) dut1 (
    .clk(clk), .rst(rst1), .bus(b1.master),
    .busy(busy1), .done(done1), .error(err1), .overflow_flag(ovf1)
  );

  matrix_job_sequencer #(.MEM_LAT(3), .ALU_TIMEOUT(255)) dut3 (
    .clk(clk), .rst(rst3), .bus(b3.master),
    .busy(busy3), .done(done3), .error(err3), .overflow_flag(ovf3)
  );

  function automatic logic [VEC_W-1:0] lane_add(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = a[k*DATA_W +: DATA_W] + b[k*DATA_W +: DATA_W];
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory models: dut1 one-cycle read, dut3 three-cycle read pipeline.
  always @(posedge clk) begin
    rd1 <= mem1[b1.mem_addr];
    p0  <= mem3[b3.mem_addr];
    p1  <= p0;
    p2  <= p1;
  end
  assign b1.mem_rdata = rd1;
  assign b3.mem_rdata = p2;

  // ALU models: done two edges after the start pulse is seen, unless hung.
  always @(posedge clk) begin
    st1         <= b1.alu_start & ~hang1;
    b1.alu_done <= st1;
    st3         <= b3.alu_start;
    b3.alu_done <= st3;
  end
  assign b1.alu_result   = lane_add(b1.alu_a, b1.alu_b);
  assign b3.alu_result   = lane_add(b3.alu_a, b3.alu_b);
  assign b1.alu_overflow = ovf_in1;
  assign b3.alu_overflow = 1'b0;

  // dut1 monitor
  initial begin
    int cyc = 0;
    int acc = 0;
    wr_t w; st_t s; dn_t d;
    forever begin
      @(negedge clk);
      cyc++;
      if (b1.cmd_valid && b1.cmd_ready && !rst1) acc = cyc;
      if (b1.mem_we) begin
        if (wq1.size() == 0) chk("unexpected_write1", int'(b1.mem_addr), -1);
        else begin
          w = wq1.pop_front();
          chk("wr_addr1", int'(b1.mem_addr), w.addr);
          chk("wr_data1", int'(b1.mem_wdata), w.data);
        end
      end
      if (b1.alu_start) begin
        if (sq1.size() == 0) chk("unexpected_start1", 1, 0);
        else begin
          s = sq1.pop_front();
          chk("alu_op1", int'(b1.alu_op), s.op);
          chk("alu_size1", int'(b1.alu_size), s.size);
          chk("alu_a_lane1", int'(b1.alu_a[s.lane*DATA_W +: DATA_W]), s.aval);
        end
      end
      if (done1) begin
        if (dq1.size() == 0) chk("unexpected_done1", 1, 0);
        else begin
          d = dq1.pop_front();
          chk("done_error1", int'(err1), d.err);
          chk("done_ovf1", int'(ovf1), d.ovf);
          chk("writes_left1", wq1.size(), 0);
          if (d.lat > 0) chk("latency1", cyc - acc, d.lat);
        end
      end
    end
  end

  // dut3 monitor
  initial begin
    int cyc = 0;
    int acc = 0;
    wr_t w; st_t s; dn_t d;
    forever begin
      @(negedge clk);
      cyc++;
      if (b3.cmd_valid && b3.cmd_ready && !rst3) acc = cyc;
      if (b3.mem_we) begin
        if (wq3.size() == 0) chk("unexpected_write3", int'(b3.mem_addr), -1);
        else begin
          w = wq3.pop_front();
          chk("wr_addr3", int'(b3.mem_addr), w.addr);
          chk("wr_data3", int'(b3.mem_wdata), w.data);
        end
      end
      if (b3.alu_start) begin
        if (sq3.size() == 0) chk("unexpected_start3", 1, 0);
        else begin
          s = sq3.pop_front();
          chk("alu_op3", int'(b3.alu_op), s.op);
          chk("alu_size3", int'(b3.alu_size), s.size);
          chk("alu_a_lane3", int'(b3.alu_a[s.lane*DATA_W +: DATA_W]), s.aval);
        end
      end
      if (done3) begin
        if (dq3.size() == 0) chk("unexpected_done3", 1, 0);
        else begin
          d = dq3.pop_front();
          chk("done_error3", int'(err3), d.err);
          chk("writes_left3", wq3.size(), 0);
          if (d.lat > 0) chk("latency3", cyc - acc, d.lat);
        end
      end
    end
  end

  task automatic issue1(input int op, input int size);
    @(posedge clk); #1;
    b1.cmd_op = 3'(op); b1.cmd_size = 2'(size); b1.cmd_valid = 1'b1;
    @(posedge clk); #1;
    b1.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget);
    int n = 0;
    while (((which == 1) ? done1 : done3) !== 1'b1 && n < budget) begin
      @(negedge clk); n++;
    end
    chk((which == 1) ? "done_seen1" : "done_seen3", int'((which == 1) ? done1 : done3), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst1 = 1'b1; rst3 = 1'b1;
    b1.cmd_valid = 1'b0; b1.cmd_op = 3'd0; b1.cmd_size = 2'd0;
    b3.cmd_valid = 1'b0; b3.cmd_op = 3'd0; b3.cmd_size = 2'd0;
    for (int k = 0; k < 128; k++) begin mem1[k] = 16'h0000; mem3[k] = 16'h0000; end
    mem1[0]  = {8'd8, 8'd2};    mem1[1]  = {8'd14, 8'd32};  mem1[2]  = {8'd3, 8'd4};
    mem1[5]  = {8'd76, 8'd5};   mem1[6]  = {8'd1, 8'd18};   mem1[7]  = {8'd10, 8'd20};
    mem1[10] = {8'd100, 8'd50}; mem1[11] = {8'd255, 8'd1};  mem1[12] = {8'd9, 8'd9};
    for (int k = 0; k < LANES; k++) mem3[k] = {8'(2*k), 8'(k+3)};

    // reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_ready1", int'(b1.cmd_ready), 1);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_we1", int'(b1.mem_we), 0);
    chk("rst_addr1", int'(b1.mem_addr), 0);
    chk("rst_alu_a1", int'(b1.alu_a != '0), 0);
    chk("rst_start1", int'(b1.alu_start), 0);
    chk("rst_err1", int'(err1), 0);
    chk("rst_ready3", int'(b3.cmd_ready), 1);
    rst1 = 1'b0; rst3 = 1'b0;

    // 2x2 add with a rejected command during COMPUTE
    wq1.push_back('{25, 10}); wq1.push_back('{26, 46});
    wq1.push_back('{30, 81}); wq1.push_back('{31, 19});
    sq1.push_back('{0, 0, 6, 18});
    dq1.push_back('{0, 0, 16});
    issue1(0, 0);
    n = 0;
    while (b1.alu_start !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("start_seen1", int'(b1.alu_start), 1);
    @(posedge clk); #1;
    b1.cmd_op = 3'd5; b1.cmd_size = 2'd3; b1.cmd_valid = 1'b1;
    chk("busy_ready1", int'(b1.cmd_ready), 0);
    chk("busy_busy1", int'(busy1), 1);
    @(posedge clk); #1;
    b1.cmd_valid = 1'b0; b1.cmd_op = 3'd0; b1.cmd_size = 2'd0;
    wait_done(1, 60);
    repeat (5) @(posedge clk); #1;
    chk("reject_idle1", int'(busy1), 0);

    // reset mid LOAD_WAIT aborts without writes
    issue1(0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_lane0", int'(b1.alu_a[7:0]), 2);
    @(posedge clk); #1;
    rst1 = 1'b1; #1;
    chk("midrst_we1", int'(b1.mem_we), 0);
    chk("midrst_busy1", int'(busy1), 0);
    chk("midrst_ready1", int'(b1.cmd_ready), 1);
    chk("midrst_alu_a1", int'(b1.alu_a != '0), 0);
    @(posedge clk); #1;
    rst1 = 1'b0;
    repeat (30) @(posedge clk); #1;
    chk("post_rst_idle1", int'(busy1), 0);

    // ALU timeout: error, no writes, done pulse, back to IDLE
    hang1 = 1'b1;
    sq1.push_back('{2, 0, 0, 2});
    dq1.push_back('{1, 0, 0});
    issue1(2, 0);
    wait_done(1, 100);
    chk("tmo_error_sticky1", int'(err1), 1);
    chk("tmo_idle1", int'(b1.cmd_ready), 1);
    hang1 = 1'b0;

    // 3x3 add with ALU overflow, includes a wrapping lane
    ovf_in1 = 1'b1;
    wq1.push_back('{25, 10}); wq1.push_back('{26, 46}); wq1.push_back('{27, 7});
    wq1.push_back('{30, 81}); wq1.push_back('{31, 19}); wq1.push_back('{32, 30});
    wq1.push_back('{35, 150}); wq1.push_back('{36, 0}); wq1.push_back('{37, 18});
`ifdef MATRIX_SEQ_OVF_WORD_EN
    wq1.push_back('{50, 1});
    dq1.push_back('{0, 1, 32});
`else
    dq1.push_back('{0, 1, 31});
`endif
    sq1.push_back('{0, 1, 12, 9});
    issue1(0, 1);
    chk("err_cleared1", int'(err1), 0);
    wait_done(1, 100);
    chk("ovf_port1", int'(ovf1), 1);
    ovf_in1 = 1'b0;

    // 5x5 on the three-cycle memory
    for (int k = 0; k < LANES; k++) wq3.push_back('{25 + k, 3*k + 3});
    sq3.push_back('{0, 3, 24, 27});
    dq3.push_back('{0, 0, 129});
    @(posedge clk); #1;
    b3.cmd_op = 3'd0; b3.cmd_size = 2'd3; b3.cmd_valid = 1'b1;
    @(posedge clk); #1;
    b3.cmd_valid = 1'b0;
    wait_done(3, 400);

    repeat (5) @(posedge clk); #1;
    chk("final_wq1", wq1.size(), 0);
    chk("final_wq3", wq3.size(), 0);
    chk("final_dq1", dq1.size(), 0);
    chk("final_sq3", sq3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
